adder32: RTL and testbench
==========================

Name: adder32

Overview:
- 32-bit binary adder with carry-in and carry-out; result and carry are registered.
- Used as the arithmetic core of the lab datapath. The subtract path feeds it with an inverted B operand and Cin=1.
- Internally built as eight 4-bit carry-lookahead groups chained by ripple carry, followed by one output register stage.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of 4; only 32 is required to be verified.

Ports:
- clk  input  1  single clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- A  input  WIDTH  operand A, unsigned or two's complement
- B  input  WIDTH  operand B
- Cin  input  1  carry-in, added at bit 0
- S  output  WIDTH  registered sum bits [WIDTH-1:0]
- Cout  output  1  registered carry-out of the MSB

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, S=0 and Cout=0 immediately, independent of clk. Release is synchronous to the next rising clk edge in system integration.
- Function: {Cout,S} = A + B + Cin, computed as full WIDTH+1-bit unsigned arithmetic. No saturation. Overflow shows only as Cout.
- Latency: 1 cycle.
  - On each rising clk edge with rst_n=1, S and Cout load the combinational result of the A/B/Cin values present at that edge.
  - Outputs hold between edges.
- Throughput: one new operation per cycle. There is no handshake and no enable; the block samples every cycle.
- Internal structure:
  - Per-bit generate g=A&B and propagate p=A^B.
  - Each 4-bit group computes c1..c4 by lookahead from its group carry-in.
  - Group carry-out c4 feeds the next group. Group 0 takes Cin.
  - Sum bit = p ^ carry-in of that bit.
- Wrap-around: all-ones + 1 gives S=0 and Cout=1. All-ones + all-ones + 1 gives S=all-ones and Cout=1.
- Signed use: Cout is an unsigned carry only. No overflow flag is provided.
- X/Z on inputs: no requirement; the result is undefined.
- Reset mid-operation: asserting rst_n clears the outputs at once, and any in-flight result is discarded. The first valid result appears one edge after release.
- Inputs changing between edges have no effect on the outputs until the next edge.

Test Plan:
- Reset, then A=0, B=0, Cin=0 -> S=00000000, Cout=0. Also check outputs read 0 while rst_n=0.
- A=1, B=1, Cin=0 -> S=00000002, Cout=0. A=0, B=0, Cin=1 -> S=00000001, Cout=0.
- A=FFFFFFFF, B=1, Cin=0 -> S=00000000, Cout=1 (wrap-around). A=FFFFFFFF, B=FFFFFFFF, Cin=1 -> S=FFFFFFFF, Cout=1.
- A=15 (dec), B=5 (dec), Cin=1 -> S=00000015 (hex, 21 dec), Cout=0.
- A=12345678, B=87654321, Cin=0 -> S=99999999, Cout=0. A=ABCDEF01, B=12345678, Cin=1 -> S=BE02457A, Cout=0.
- Back-to-back vectors on consecutive edges check the 1-cycle latency. Assert rst_n low between edges -> S=0 and Cout=0 at once. Then apply at least 1000 random vectors, each compared against a {1'b0,A}+B+Cin model.

Source files
------------

// File: rtl/adder32_if.sv
// Operand/result bundle for the adder32 arithmetic core.
interface adder32_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (output A, output B, output Cin, input S, input Cout);
  modport slave  (input A, input B, input Cin, output S, output Cout);
endinterface

// File: rtl/adder32.sv
// adder32: WIDTH-bit adder with carry-in/carry-out and one registered
// output stage. Built from 4-bit carry-lookahead groups whose group
// carries ripple from group to group.
module adder32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  adder32_if.slave  bus
);

  localparam int unsigned NGROUPS = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             gcin;
  logic [3:0]       gg;
  logic [3:0]       pp;
  logic [4:1]       gc;

  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  // Per-bit generate and propagate terms.
  always_comb begin
    g = bus.A & bus.B;
    p = bus.A ^ bus.B;
  end

  // Lookahead inside each 4-bit group; group carry-out feeds the next group.
  always_comb begin
    carry = '0;
    gcin  = bus.Cin;
    gg    = '0;
    pp    = '0;
    gc    = '0;
    for (int unsigned k = 0; k < NGROUPS; k++) begin
      gg    = g[4*k +: 4];
      pp    = p[4*k +: 4];
      gc[1] = gg[0] | (pp[0] & gcin);
      gc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gcin);
      gc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
            | (pp[2] & pp[1] & pp[0] & gcin);
      gc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0])
            | (pp[3] & pp[2] & pp[1] & pp[0] & gcin);
      carry[4*k +: 4] = {gc[3], gc[2], gc[1], gcin};
      gcin = gc[4];
    end
    cout_c = gcin;
    sum_c  = p ^ carry;
  end

  // Output register: loads the combinational result every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= sum_c;
      cout_q <= cout_c;
    end
  end

  assign bus.S    = s_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_adder32.sv
// Directed and random checks for adder32.
module tb_adder32;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  adder32_if #(.WIDTH(32)) bus ();

  adder32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] expv);
    logic [32:0] obs;
    obs = {bus.Cout, bus.S};
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed {Cout,S}=%h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
    bus.A   = a;
    bus.B   = b;
    bus.Cin = c;
  endtask

  // Drive at negedge, check #1 after the following posedge.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [32:0] expv);
    @(negedge clk);
    drive(a, b, c);
    @(posedge clk);
    #1;
    check(tag, expv);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] model;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(32'hDEADBEEF, 32'h12345678, 1'b1);

    // Outputs stay zero while reset is held, even across clock edges.
    #2;
    check("reset_async", 33'h0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 33'h0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("zero", 33'h0);

    step("one_plus_one", 32'h1,        32'h1,        1'b0, 33'h0_00000002);
    step("cin_only",     32'h0,        32'h0,        1'b1, 33'h0_00000001);
    step("wrap",         32'hFFFFFFFF, 32'h1,        1'b0, 33'h1_00000000);
    step("all_ones",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF);
    step("dec15_5_1",    32'd15,       32'd5,        1'b1, 33'h0_00000015);
    step("pattern1",     32'h12345678, 32'h87654321, 1'b0, 33'h0_99999999);
    step("pattern2",     32'hABCDEF01, 32'h12345678, 1'b1, 33'h0_BE02457A);
    step("carry_chain",  32'h0000FFFF, 32'h00000000, 1'b1, 33'h0_00010000);
    step("msb_carry",    32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000);

    // New inputs between edges must not reach the outputs before the edge.
    @(negedge clk);
    drive(32'h00000010, 32'h00000020, 1'b0);
    #1;
    check("hold_before_edge", 33'h1_00000000);
    @(posedge clk);
    #1;
    check("latency_1", 33'h0_00000030);
    // Back-to-back: next vector on the very next edge.
    drive(32'h7FFFFFFF, 32'h00000001, 1'b0);
    @(posedge clk);
    #1;
    check("latency_2", 33'h0_80000000);

    // Reset asserted between edges clears outputs immediately.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h00000003, 32'h00000004, 1'b1);
    #1;
    check("reset_release_hold", 33'h0);
    @(posedge clk);
    #1;
    check("after_release", 33'h0_00000008);

    for (int i = 0; i < 1000; i++) begin
      ra    = $urandom;
      rb    = $urandom;
      rc    = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      step("random", ra, rb, rc, model);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
